keypad_scan_debounce: RTL and testbench
=======================================

// Module: keypad_scan_debounce
// PURPOSE
//  Scans the 3-column x 4-row ATM keypad, debounces it and registers one key code per physical press.
//  The code is held until the CPU acknowledges it. buttonPressed feeds the MMIO read mux at address 0.
//  acknowledgeKey is the CPU-written MMIO register at address 22.
// PARAMETERS
//  SCAN_DIV         30000  clock cycles per row slot (1 ms at 30 MHz); minimum 2
//  DEBOUNCE_SWEEPS  5      consecutive identical full sweeps needed to accept a press or a release; minimum 1
// PORTS
//  clock          in   1   system clock (30 MHz PLL output); single clock domain
//  reset          in   1   synchronous, active-high
//  cols           in   3   column inputs, active-low (pulled up); synchronised inside this block by 2 flops
//  rows           out  4   row drive, active-low one-hot; row0 = {1,2,3}, row1 = {4,5,6}, row2 = {7,8,9}, row3 = {*,0,#}
//  acknowledgeKey in   32  CPU ack; only bit 0 is used; a rising edge acknowledges the held key
//  buttonPressed  out  4   held key code: 0-9 digits, 4'hA = *, 4'hB = #, 4'hF = none
//  key_valid      out  1   high while buttonPressed holds an unacknowledged code
//  dbg_led        out  10  one-hot of the held digit (bit n = digit n); 0 for *, # or none
// BEHAVIOUR
//  Reset values: rows = 4'b1110, buttonPressed = 4'hF, key_valid = 0, dbg_led = 0, state = SCAN.
//   All counters = 0; ack_prev = 0; sync flops = 3'b111.
//  Row scan: the active row advances 0->1->2->3->0 every SCAN_DIV cycles and runs in every state.
//  Column sampling: the synchronised cols are sampled in the last cycle of each row slot, which gives the row time to settle.
//  A sweep is 4 slots. At the end of each sweep the 12 samples give a candidate:
//   - exactly one key down -> that key's code
//   - zero keys down -> NONE
//   - two or more keys down -> NONE (multi-key presses are ignored)
//  Stability counter (stab_cnt) and last candidate (cand_prev):
//   - If candidate == cand_prev, stab_cnt increments and saturates at DEBOUNCE_SWEEPS.
//   - Otherwise stab_cnt = 1 and cand_prev = candidate.
//   - The debounced value is "stable" when stab_cnt == DEBOUNCE_SWEEPS.
//  Ack edge: ack_edge = acknowledgeKey[0] & ~ack_prev. ack_prev is registered every cycle.
//  FSM:
//   SCAN: a stable non-NONE candidate latches the code.
//     - buttonPressed = code, key_valid = 1, dbg_led is updated, all in the cycle after the sweep end.
//     - Next state is LATCHED and the released flag is cleared.
//     - ack_edge is ignored in SCAN.
//   LATCHED: outputs hold. A stable NONE sets the released flag.
//     - ack_edge -> buttonPressed = 4'hF, key_valid = 0, dbg_led = 0 in the next cycle.
//     - After the ack, go to SCAN if released = 1, otherwise WAIT_RELEASE.
//     - Other presses are ignored while in LATCHED.
//   WAIT_RELEASE: outputs stay at their none values. A stable NONE -> SCAN.
//     - ack_edge is ignored in WAIT_RELEASE.
//  One press gives exactly one code; there is no auto-repeat.
//  A key held across its ack is not re-registered until it has been released and stable.
//  Simultaneous events: if ack_edge occurs in the same cycle as a sweep end, the ack is applied first.
//   That sweep's candidate is still evaluated for the released flag.
//  Latency: a clean press first seen in sweep k is latched 1 cycle after the end of sweep k+DEBOUNCE_SWEEPS-1.
//  Reset mid-press: all state is lost. A key still held after reset is registered again once it is stable.
// STRUCTURE
//  keypad_pkg holds:
//   - key code localparams KEY_NONE = 4'hF, KEY_STAR = 4'hA, KEY_HASH = 4'hB
//   - the {row, col} -> code map
//   - state encodings SCAN / LATCHED / WAIT_RELEASE
//  Sub-module keypad_row_scanner owns the slot divider, row rotation, sample strobe and sweep_done pulse.
//  The top level owns candidate decode, debounce and the FSM.
// TESTING (SCAN_DIV = 4, DEBOUNCE_SWEEPS = 3)
//  Reset: reset held 2 cycles -> rows = 1110, buttonPressed = F, key_valid = 0, dbg_led = 0.
//   Rows then rotate with a period of 16 cycles.
//  Clean press of '5' (row1/col1 low): code latched 1 cycle after the 3rd sweep end.
//   -> buttonPressed = 5, key_valid = 1, dbg_led = 10'b0000100000.
//  Bounce: '8' toggled every sweep for 4 sweeps and then held -> no latch until 3 consecutive stable '8' sweeps; exactly one code 8.
//  Hold across ack: '#' latched and acked while still held -> F, valid = 0, state WAIT_RELEASE.
//   The key stays held for 10 sweeps with no new latch. After release and 3 NONE sweeps -> SCAN.
//  Multi-key: '1' and '3' pressed together -> no latch. Releasing '3' -> '1' latches after 3 sweeps.
//  Ack held high from reset and ack pulses in SCAN: no effect. A second press while in LATCHED is ignored and the code stays at the first key.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, keypad position-to-code map and FSM state encodings
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        LATCHED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Position index is row*3 + col, row0 = {1,2,3} ... row3 = {*,0,#}
    function automatic logic [3:0] key_code(input int idx);
        case (idx)
            0:       key_code = 4'h1;
            1:       key_code = 4'h2;
            2:       key_code = 4'h3;
            3:       key_code = 4'h4;
            4:       key_code = 4'h5;
            5:       key_code = 4'h6;
            6:       key_code = 4'h7;
            7:       key_code = 4'h8;
            8:       key_code = 4'h9;
            9:       key_code = KEY_STAR;
            10:      key_code = 4'h0;
            11:      key_code = KEY_HASH;
            default: key_code = KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// rtl/keypad_row_scanner.sv - row slot divider, active-low row rotation, sample strobe and sweep_done pulse
module keypad_row_scanner #(
    parameter int SCAN_DIV = 30000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] rows,
    output logic [1:0] row_idx,
    output logic       sample,
    output logic       sweep_done
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] slot_cnt_q;
    logic [1:0]    row_q;

    // Columns are read at the very end of a slot so the row drive has settled
    assign sample     = (slot_cnt_q == CW'(SCAN_DIV - 1));
    assign sweep_done = sample && (row_q == 2'd3);
    assign rows       = ~(4'b0001 << row_q);
    assign row_idx    = row_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt_q <= '0;
            row_q      <= 2'd0;
        end else if (sample) begin
            slot_cnt_q <= '0;
            row_q      <= row_q + 2'd1;
        end else begin
            slot_cnt_q <= slot_cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// rtl/keypad_scan_debounce.sv - 3x4 keypad scan, sweep-level debounce and one-code-per-press latch with CPU ack
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 30000,
    parameter int DEBOUNCE_SWEEPS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cols,
    output logic [3:0]  rows,
    input  logic [31:0] acknowledgeKey,
    output logic [3:0]  buttonPressed,
    output logic        key_valid,
    output logic [9:0]  dbg_led
);

    localparam int SW = $clog2(DEBOUNCE_SWEEPS + 1);

    logic [1:0]    row_idx;
    logic          sample;
    logic          sweep_done;
    logic [2:0]    cols_meta_q, cols_sync_q;
    logic [11:0]   samples_q;
    logic [11:0]   sweep_vec;
    logic [3:0]    n_down;
    logic [3:0]    hit_code;
    logic [3:0]    cand;
    logic [3:0]    cand_prev_q, cand_prev_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          ack_prev_q;
    logic          ack_edge;
    logic          stable_now, stable_none, stable_key;
    state_t        state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic          released_q, released_d;
    logic          unused_ack_bits;

    keypad_row_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clock      (clock),
        .reset      (reset),
        .rows       (rows),
        .row_idx    (row_idx),
        .sample     (sample),
        .sweep_done (sweep_done)
    );

    assign unused_ack_bits = ^acknowledgeKey[31:1];
    assign ack_edge        = acknowledgeKey[0] & ~ack_prev_q;

    // Row 3's sample lands in the same cycle as sweep_done, so it is merged in directly
    always_comb begin
        sweep_vec        = samples_q;
        sweep_vec[11:9]  = ~cols_sync_q;
        n_down           = 4'd0;
        hit_code         = KEY_NONE;
        for (int i = 0; i < 12; i++) begin
            if (sweep_vec[i]) begin
                n_down   = n_down + 4'd1;
                hit_code = key_code(i);
            end
        end
        cand = (n_down == 4'd1) ? hit_code : KEY_NONE;
    end

    always_comb begin
        cand_prev_d = cand_prev_q;
        stab_cnt_d  = stab_cnt_q;
        if (sweep_done) begin
            if (cand == cand_prev_q) begin
                if (stab_cnt_q != SW'(DEBOUNCE_SWEEPS))
                    stab_cnt_d = stab_cnt_q + SW'(1);
            end else begin
                stab_cnt_d  = SW'(1);
                cand_prev_d = cand;
            end
        end
        stable_now  = sweep_done && (stab_cnt_d == SW'(DEBOUNCE_SWEEPS));
        stable_none = stable_now && (cand == KEY_NONE);
        stable_key  = stable_now && (cand != KEY_NONE);
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        released_d = released_q;
        case (state_q)
            SCAN: begin
                if (stable_key) begin
                    code_d     = cand;
                    released_d = 1'b0;
                    state_d    = LATCHED;
                end
            end
            LATCHED: begin
                if (stable_none)
                    released_d = 1'b1;
                if (ack_edge) begin
                    code_d  = KEY_NONE;
                    state_d = (released_q || stable_none) ? SCAN : WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (stable_none)
                    state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
                code_d  = KEY_NONE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cols_meta_q <= 3'b111;
            cols_sync_q <= 3'b111;
            samples_q   <= '0;
            cand_prev_q <= KEY_NONE;
            stab_cnt_q  <= '0;
            ack_prev_q  <= 1'b0;
            state_q     <= SCAN;
            code_q      <= KEY_NONE;
            released_q  <= 1'b0;
        end else begin
            cols_meta_q <= cols;
            cols_sync_q <= cols_meta_q;
            if (sample)
                samples_q[int'(row_idx) * 3 +: 3] <= ~cols_sync_q;
            cand_prev_q <= cand_prev_d;
            stab_cnt_q  <= stab_cnt_d;
            ack_prev_q  <= acknowledgeKey[0];
            state_q     <= state_d;
            code_q      <= code_d;
            released_q  <= released_d;
        end
    end

    assign buttonPressed = code_q;
    assign key_valid     = (state_q == LATCHED);
    assign dbg_led       = (code_q < 4'd10) ? (10'd1 << code_q) : 10'd0;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb/tb_keypad_scan_debounce.sv - directed bench with a behavioural keypad matrix driving the columns
module tb_keypad_scan_debounce;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cols;
    logic [3:0]  rows;
    logic [31:0] acknowledgeKey;
    logic [3:0]  buttonPressed;
    logic        key_valid;
    logic [9:0]  dbg_led;
    logic [11:0] keys;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [11:0] K1 = 12'd1 << 0;
    localparam logic [11:0] K2 = 12'd1 << 1;
    localparam logic [11:0] K3 = 12'd1 << 2;
    localparam logic [11:0] K5 = 12'd1 << 4;
    localparam logic [11:0] K7 = 12'd1 << 6;
    localparam logic [11:0] K8 = 12'd1 << 7;
    localparam logic [11:0] K9 = 12'd1 << 8;
    localparam logic [11:0] KH = 12'd1 << 11;

    keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_SWEEPS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .cols           (cols),
        .rows           (rows),
        .acknowledgeKey (acknowledgeKey),
        .buttonPressed  (buttonPressed),
        .key_valid      (key_valid),
        .dbg_led        (dbg_led)
    );

    always #5 clock = ~clock;

    always_comb begin
        cols = 3'b111;
        for (int r = 0; r < 4; r++)
            if (!rows[r])
                for (int c = 0; c < 3; c++)
                    if (keys[r * 3 + c]) cols[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic ack_level);
        reset          = 1'b1;
        keys           = '0;
        acknowledgeKey = {31'd0, ack_level};
        tick(2);
        reset = 1'b0;
    endtask

    task automatic ack_pulse;
        acknowledgeKey = 32'd1;
        tick(1);
        acknowledgeKey = 32'd0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] code, input logic valid, input logic [9:0] led);
        check({tag, "_code"}, {28'd0, buttonPressed}, {28'd0, code});
        check({tag, "_valid"}, {31'd0, key_valid}, {31'd0, valid});
        check({tag, "_led"}, {22'd0, dbg_led}, {22'd0, led});
    endtask

    initial begin
        // reset state and row rotation
        do_reset(1'b0);
        check("rst_rows", {28'd0, rows}, 32'b1110);
        check_out("rst", 4'hF, 1'b0, 10'd0);
        tick(4);  check("rows_r1", {28'd0, rows}, 32'b1101);
        tick(4);  check("rows_r2", {28'd0, rows}, 32'b1011);
        tick(4);  check("rows_r3", {28'd0, rows}, 32'b0111);
        tick(4);  check("rows_wrap", {28'd0, rows}, 32'b1110);

        // clean '5' press: latched one cycle after the 3rd sweep end (edge 48)
        do_reset(1'b0);
        keys = K5;
        tick(47); check("p5_early", {31'd0, key_valid}, 32'd0);
        tick(1);  check_out("p5", 4'h5, 1'b1, 10'b0000100000);
        keys = '0;
        tick(48); check("p5_hold", {28'd0, buttonPressed}, 32'h5);
        ack_pulse();
        check_out("p5_ack", 4'hF, 1'b0, 10'd0);

        // bouncing '8': toggled for 4 sweeps, then held; latches at edge 112
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? K8 : 12'd0;
            tick(16);
            check("b8_none", {31'd0, key_valid}, 32'd0);
        end
        keys = K8;
        tick(47); check("b8_early", {31'd0, key_valid}, 32'd0);
        tick(1);  check_out("b8", 4'h8, 1'b1, 10'b0100000000);
        tick(64); check_out("b8_once", 4'h8, 1'b1, 10'b0100000000);

        // '#' acked while still held: no re-registration until released
        do_reset(1'b0);
        keys = KH;
        tick(48); check_out("h_latch", 4'hB, 1'b1, 10'd0);
        ack_pulse();
        check_out("h_ack", 4'hF, 1'b0, 10'd0);
        tick(160); check_out("h_held", 4'hF, 1'b0, 10'd0);
        ack_pulse();
        check("h_ack_wait", {31'd0, key_valid}, 32'd0);
        keys = '0;
        tick(64);
        keys = K2;
        tick(64); check_out("h_next", 4'h2, 1'b1, 10'b0000000100);

        // '1' and '3' together ignored; '1' alone latches 3 sweeps after '3' lifts
        do_reset(1'b0);
        keys = K1 | K3;
        tick(80); check("m_none", {31'd0, key_valid}, 32'd0);
        keys = K1;
        tick(47); check("m_early", {31'd0, key_valid}, 32'd0);
        tick(1);  check_out("m_one", 4'h1, 1'b1, 10'b0000000010);

        // ack held high from reset and pulses in SCAN have no effect; second press while latched ignored
        do_reset(1'b1);
        tick(20);
        acknowledgeKey = 32'd0; tick(2);
        ack_pulse(); tick(2);
        check_out("a_scan", 4'hF, 1'b0, 10'd0);
        acknowledgeKey = 32'd1;
        keys = K7;
        tick(64); check_out("a_seven", 4'h7, 1'b1, 10'b0010000000);
        keys = '0;
        tick(64);
        keys = K9;
        tick(80); check_out("a_second", 4'h7, 1'b1, 10'b0010000000);
        acknowledgeKey = 32'd0; tick(1);
        ack_pulse();
        check_out("a_ack", 4'hF, 1'b0, 10'd0);
        tick(16); check_out("a_nine", 4'h9, 1'b1, 10'b1000000000);

        // reset mid-press: state lost, held key registered again once stable
        reset = 1'b1; tick(2); reset = 1'b0;
        check_out("r_mid", 4'hF, 1'b0, 10'd0);
        tick(48); check_out("r_again", 4'h9, 1'b1, 10'b1000000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
